// File: rtl/rng_pkg.sv
// Shared LFSR definitions for the rng arbiter family.
// Holds the LFSR width, tap mask, step function and FSM state enum.
package rng_pkg;

    localparam int LFSR_W = 16;

    // Taps for x^16+x^14+x^13+x^11+1 in the shift-left form (bits 15,13,12,10)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        ADVANCE,
        GRANT
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/rng_arbiter_rr_pick.sv
// Round-robin picker: first set req bit scanning upward from ptr, with wrap.
// Ports: req, ptr in; found, onehot, idx out. Purely combinational.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    logic [IW:0]   pos;
    logic [IW-1:0] sel;

    always_comb begin
        found  = 1'b0;
        onehot = '0;
        idx    = '0;
        pos    = '0;
        sel    = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            sel = pos[IW-1:0];
            if (!found && req[sel]) begin
                found       = 1'b1;
                idx         = sel;
                onehot[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rng_arbiter.sv
// Shares one 16-bit Fibonacci LFSR among N_REQ requesters, round-robin.
// Ports: clk, rst (async high), req, reseed_valid/data/ready, grant, rnd_valid, rnd_data.
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int               N_REQ    = 4,
    parameter logic [LFSR_W-1:0] SEED    = 16'hA5A5,
    parameter int               STEPS    = 1,
    parameter bit               FREE_RUN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic              reseed_valid,
    input  logic [LFSR_W-1:0] reseed_data,
    output logic              reseed_ready,
    output logic [N_REQ-1:0]  grant,
    output logic              rnd_valid,
    output logic [LFSR_W-1:0] rnd_data
);

    localparam int IW = $clog2(N_REQ);

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [N_REQ-1:0]  sel_q, sel_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              rnd_valid_q, rnd_valid_d;
    logic [LFSR_W-1:0] rnd_data_q, rnd_data_d;

    logic              pick_found;
    logic [N_REQ-1:0]  pick_onehot;
    logic [IW-1:0]     pick_idx;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .found  (pick_found),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        grant_d     = '0;
        rnd_valid_d = 1'b0;
        rnd_data_d  = rnd_data_q;
        unique case (state_q)
            IDLE: begin
                // Reseed outranks requests; a pending req simply waits a cycle
                if (reseed_valid) begin
                    lfsr_d = (reseed_data == '0) ? SEED : reseed_data;
                end else if (pick_found) begin
                    idx_d   = pick_idx;
                    sel_d   = pick_onehot;
                    cnt_d   = 4'(STEPS - 1);
                    state_d = ADVANCE;
                end else if (FREE_RUN) begin
                    lfsr_d = lfsr_next(lfsr_q);
                end
            end
            ADVANCE: begin
                lfsr_d = lfsr_next(lfsr_q);
                if (cnt_q == '0) begin
                    state_d = GRANT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            GRANT: begin
                grant_d     = sel_q;
                rnd_valid_d = 1'b1;
                rnd_data_d  = lfsr_q;
                ptr_d       = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            ptr_q       <= '0;
            idx_q       <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            rnd_valid_q <= 1'b0;
            rnd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_data_q  <= rnd_data_d;
        end
    end

    assign reseed_ready = (state_q == IDLE);
    assign grant        = grant_q;
    assign rnd_valid    = rnd_valid_q;
    assign rnd_data     = rnd_data_q;

endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter: two configurations against a transaction-level model.
// Directed literal checks plus a randomized phase.
module tb_rng_arbiter;

    localparam int N  = 4;
    localparam int S0 = 1;
    localparam int S1 = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic          reseed_valid = 1'b0;
    logic [15:0]   reseed_data = '0;

    logic [N-1:0]  g  [2];
    logic          v  [2];
    logic [15:0]   d  [2];
    logic          rr [2];

    always #5 clk = ~clk;

    rng_arbiter #(.N_REQ(N), .SEED(16'hA5A5), .STEPS(S0), .FREE_RUN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req(req),
        .reseed_valid(reseed_valid), .reseed_data(reseed_data),
        .reseed_ready(rr[0]), .grant(g[0]), .rnd_valid(v[0]), .rnd_data(d[0])
    );

    rng_arbiter #(.N_REQ(N), .SEED(16'hA5A5), .STEPS(S1), .FREE_RUN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .req(req),
        .reseed_valid(reseed_valid), .reseed_data(reseed_data),
        .reseed_ready(rr[1]), .grant(g[1]), .rnd_valid(v[1]), .rnd_data(d[1])
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_shift(logic [15:0] s, int n);
        for (int k = 0; k < n; k++) begin
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        end
        return s;
    endfunction

    // Transaction-level model: a draw is "busy" for STEPS+1 edges, then granted
    int          m_steps [2] = '{S0, S1};
    bit          m_fr    [2] = '{1'b0, 1'b1};
    logic [15:0] m_lfsr  [2];
    logic [15:0] m_val   [2];
    int          m_ptr   [2];
    int          m_busy  [2];
    int          m_idx   [2];
    logic [N-1:0] e_g    [2];
    logic         e_v    [2];
    logic [15:0]  e_d    [2];

    task automatic model_step(int i);
        e_g[i] = '0;
        e_v[i] = 1'b0;
        if (rst) begin
            m_lfsr[i] = 16'hA5A5;
            m_ptr[i]  = 0;
            m_busy[i] = 0;
            m_idx[i]  = 0;
            e_d[i]    = '0;
            return;
        end
        if (m_busy[i] > 0) begin
            m_busy[i]--;
            if (m_busy[i] == 0) begin
                e_g[i]   = 4'(1) << m_idx[i];
                e_v[i]   = 1'b1;
                e_d[i]   = m_val[i];
                m_ptr[i] = (m_idx[i] + 1) % N;
            end
        end else if (reseed_valid) begin
            m_lfsr[i] = (reseed_data == 16'h0) ? 16'hA5A5 : reseed_data;
        end else if (req != '0) begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr[i] + k) % N;
                if (req[2'(p)]) begin
                    m_idx[i] = p;
                    break;
                end
            end
            m_val[i]  = ref_shift(m_lfsr[i], m_steps[i]);
            m_lfsr[i] = m_val[i];
            m_busy[i] = m_steps[i] + 1;
        end else if (m_fr[i]) begin
            m_lfsr[i] = ref_shift(m_lfsr[i], 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_lfsr[i] = 16'hA5A5; m_val[i] = '0; m_ptr[i] = 0;
            m_busy[i] = 0; m_idx[i] = 0;
            e_g[i] = '0; e_v[i] = 1'b0; e_d[i] = '0;
        end
        forever begin
            @(posedge clk);
            model_step(0);
            model_step(1);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    check($sformatf("rst_grant%0d", i), 32'(g[i]), 0);
                    check($sformatf("rst_valid%0d", i), 32'(v[i]), 0);
                    check($sformatf("rst_data%0d", i), 32'(d[i]), 0);
                    check($sformatf("rst_ready%0d", i), 32'(rr[i]), 1);
                end else begin
                    check($sformatf("grant%0d", i), 32'(g[i]), 32'(e_g[i]));
                    check($sformatf("valid%0d", i), 32'(v[i]), 32'(e_v[i]));
                    check($sformatf("data%0d", i), 32'(d[i]), 32'(e_d[i]));
                    check($sformatf("ready%0d", i), 32'(rr[i]), 32'(m_busy[i] == 0));
                end
            end
        end
    end

    task automatic wait_grant(int i, output logic [N-1:0] gg,
                              output logic [15:0] dd, output int cyc);
        gg  = '0;
        dd  = '0;
        cyc = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            #2;
            if (v[i]) begin
                gg  = g[i];
                dd  = d[i];
                cyc = c;
                return;
            end
        end
        check($sformatf("grant_timeout%0d", i), 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        reseed_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic settle();
        req = '0;
        reseed_valid = 1'b0;
        repeat (12) @(negedge clk);
        #2;
    endtask

    logic [N-1:0] gg;
    logic [15:0]  dd;
    int           cyc;
    logic [N-1:0] exp_rr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        // Single draws after reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("after_rst_grant", 32'(g[0]), 0);
        req = 4'b0001;
        wait_grant(0, gg, dd, cyc);
        check("draw1_grant", 32'(gg), 32'h1);
        check("draw1_data", 32'(dd), 32'h4B4B);
        check("draw1_latency", cyc, 3);
        wait_grant(0, gg, dd, cyc);
        check("draw2_data", 32'(dd), 32'h9696);
        check("draw2_spacing", cyc, 3);
        settle();

        // Round-robin order with all requesters held
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(0, gg, dd, cyc);
            check($sformatf("rr_grant%0d", k), 32'(gg), 32'(exp_rr[k]));
            if (k > 0) check($sformatf("rr_spacing%0d", k), cyc, 3);
        end
        settle();

        // Zero reseed substitutes the reset seed
        reseed_valid = 1'b1;
        reseed_data  = 16'h0000;
        @(negedge clk);
        #2;
        reseed_valid = 1'b0;
        req = 4'b0001;
        wait_grant(0, gg, dd, cyc);
        check("reseed0_data", 32'(dd), 32'h4B4B);
        settle();

        // Reseed together with a request: reseed wins, draw one cycle later
        reseed_valid = 1'b1;
        reseed_data  = 16'h1234;
        req = 4'b0010;
        @(negedge clk);
        #2;
        reseed_valid = 1'b0;
        wait_grant(0, gg, dd, cyc);
        check("reseed_req_grant", 32'(gg), 32'h2);
        check("reseed_req_latency", cyc, 3);
        check("reseed_req_data", 32'(dd), 32'(ref_shift(16'h1234, 1)));
        settle();

        // Reseed held while the STEPS=4 instance is busy
        req = 4'b0100;
        @(negedge clk);
        #2;
        reseed_valid = 1'b1;
        reseed_data  = 16'hBEEF;
        check("busy_ready", 32'(rr[1]), 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #2;
            if (rr[1]) break;
        end
        check("ready_with_grant", 32'(v[1]), 1);
        @(negedge clk);
        #2;
        reseed_valid = 1'b0;
        wait_grant(1, gg, dd, cyc);
        check("late_reseed_grant", 32'(gg), 32'h4);
        check("late_reseed_data", 32'(dd), 32'(ref_shift(16'hBEEF, 4)));
        settle();

        // One-cycle request pulse is still granted
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        #2;
        req = '0;
        wait_grant(0, gg, dd, cyc);
        check("pulse_grant", 32'(gg), 32'h4);
        settle();

        // Reset in the middle of a draw
        req = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_grant", 32'(g[0]), 0);
        check("midrst_valid", 32'(v[0]), 0);
        check("midrst_lfsr", 32'(dut0.lfsr_q), 32'hA5A5);
        check("midrst_ptr", 32'(dut0.ptr_q), 0);
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        settle();

        // Free-run: three idle cycles before the request
        do_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        req = 4'b0001;
        wait_grant(0, gg, dd, cyc);
        check("freerun_off_data", 32'(dd), 32'h4B4B);
        wait_grant(1, gg, dd, cyc);
        check("freerun_on_data", 32'(dd), 32'(ref_shift(16'hA5A5, 3 + S1)));
        settle();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            reseed_valid = ($urandom_range(0, 19) == 0);
            reseed_data  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        reseed_valid = 1'b0;
        repeat (20) @(negedge clk);
        #3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
